// File: rtl/spi_uc_pkg.sv
// Shared types and default constants for the microcontroller SPI responder.
// Imported by the interface, the synchroniser and the top level.
package spi_uc_pkg;

    localparam int SPI_WORD_BITS   = 16;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_e;

endpackage : spi_uc_pkg

// File: rtl/spi_slave_uc_if.sv
// Pin-level bundle between the SPI master/core side and the responder.
// The slave modport is the responder's view of the bundle.
interface spi_slave_uc_if
    import spi_uc_pkg::*;
#(
    parameter int outBits = SPI_WORD_BITS
) ();

    logic               SCK;
    logic               CSbar;
    logic               MOSI;
    logic               MISO;
    logic               MISO_OE;
    logic [outBits-1:0] DATA_TX;
    logic               TX_WE;
    logic [outBits-1:0] DATA_RX;
    logic               RX_VALID;
    logic               BUSY;
    logic               FRAME_ERR;

    modport slave (
        input  SCK, CSbar, MOSI, DATA_TX, TX_WE,
        output MISO, MISO_OE, DATA_RX, RX_VALID, BUSY, FRAME_ERR
    );

    modport master (
        output SCK, CSbar, MOSI, DATA_TX, TX_WE,
        input  MISO, MISO_OE, DATA_RX, RX_VALID, BUSY, FRAME_ERR
    );

endinterface : spi_slave_uc_if

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser followed by a history flop; reports the settled
// level plus single-cycle rise/fall strobes derived from last stage vs history.
module spi_sync_edge
    import spi_uc_pkg::*;
#(
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Clearing to 0 means a select held low through reset never looks like a new falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule : spi_sync_edge

// File: rtl/spi_slave_uc.sv
// SPI responder: oversamples SCK/CSbar/MOSI on SYS_CLK, samples MOSI and
// advances MISO on SCK falling edges, and reports complete or aborted frames.
module spi_slave_uc
    import spi_uc_pkg::*;
#(
    parameter int outBits     = SPI_WORD_BITS,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic           SYS_CLK,
    input  logic           RSTbar,
    spi_slave_uc_if.slave  bus
);

    localparam int CNT_W = $clog2(outBits + 1);

    logic sck_fall, cs_rise, cs_fall, mosi_lvl;
    logic sck_lvl_unused, sck_rise_unused, cs_lvl_unused;
    logic [1:0] mosi_edges_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(SYS_CLK), .rst_n(RSTbar), .d(bus.SCK),
        .level(sck_lvl_unused), .rise(sck_rise_unused), .fall(sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(SYS_CLK), .rst_n(RSTbar), .d(bus.CSbar),
        .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(SYS_CLK), .rst_n(RSTbar), .d(bus.MOSI),
        .level(mosi_lvl), .rise(mosi_edges_unused[0]), .fall(mosi_edges_unused[1])
    );

    spi_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [outBits-1:0] rx_shift_q, rx_shift_d;
    logic [outBits-1:0] tx_shift_q, tx_shift_d;
    logic [outBits-1:0] tx_hold_q, tx_hold_d;
    logic [outBits-1:0] data_rx_q, data_rx_d;
    logic [outBits-1:0] rx_next;
    logic               miso_q, miso_d;
    logic               oe_q, oe_d;
    logic               busy_q, busy_d;
    logic               rx_valid_q, rx_valid_d;
    logic               frame_err_q, frame_err_d;

    // The MSBs only matter once shifted out or captured via rx_next.
    logic unused_msbs;
    assign unused_msbs = ^{rx_shift_q[outBits-1], tx_shift_q[outBits-1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_hold_d   = bus.TX_WE ? bus.DATA_TX : tx_hold_q;
        data_rx_d   = data_rx_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        busy_d      = busy_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        rx_next     = {rx_shift_q[outBits-2:0], mosi_lvl};

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                oe_d   = 1'b0;
                busy_d = 1'b0;
                // tx_hold_d already carries a coincident TX_WE (write-through).
                if (cs_fall) begin
                    tx_shift_d = tx_hold_d;
                    miso_d     = tx_hold_d[outBits-1];
                    oe_d       = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    miso_d      = 1'b0;
                    oe_d        = 1'b0;
                    busy_d      = 1'b0;
                    frame_err_d = (cnt_q != '0);
                end else if (sck_fall) begin
                    rx_shift_d = rx_next;
                    tx_shift_d = {tx_shift_q[outBits-2:0], 1'b0};
                    miso_d     = tx_shift_q[outBits-2];
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(outBits - 1)) begin
                        data_rx_d  = rx_next;
                        rx_valid_d = 1'b1;
                        miso_d     = 1'b0;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                miso_d = 1'b0;
                if (cs_rise) begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
                oe_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (!RSTbar) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            tx_hold_q   <= '0;
            data_rx_q   <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_hold_q   <= tx_hold_d;
            data_rx_q   <= data_rx_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.MISO      = miso_q;
    assign bus.MISO_OE   = oe_q;
    assign bus.DATA_RX   = data_rx_q;
    assign bus.RX_VALID  = rx_valid_q;
    assign bus.BUSY      = busy_q;
    assign bus.FRAME_ERR = frame_err_q;

endmodule : spi_slave_uc

// File: tb/tb_spi_slave_uc.sv
// Directed bench for spi_slave_uc: a table of whole frames plus hand-written
// sequences for mid-frame TX writes, write-through and reset during a frame.
module tb_spi_slave_uc;
    import spi_uc_pkg::*;

    localparam int W = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    spi_slave_uc_if #(.outBits(W)) bus ();

    spi_slave_uc #(.outBits(W), .SYNC_STAGES(2)) dut (
        .SYS_CLK(clk),
        .RSTbar (rstn),
        .bus    (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int rxv_cnt = 0;
    int ferr_cnt = 0;

    always @(posedge clk) begin
        if (bus.RX_VALID === 1'b1)  rxv_cnt  <= rxv_cnt + 1;
        if (bus.FRAME_ERR === 1'b1) ferr_cnt <= ferr_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [15:0] tx;
        int          nbits;
        logic [31:0] mosi;
        logic [15:0] exp_rx;
        logic [31:0] exp_cap;
        int          exp_rxv;
        int          exp_ferr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_tx(input logic [15:0] d);
        bus.DATA_TX = d;
        bus.TX_WE   = 1'b1;
        cyc(1);
        bus.TX_WE   = 1'b0;
    endtask

    // With wt set, TX_WE lands on the same SYS_CLK edge that acts on the select edge.
    task automatic start_frame(input bit wt, input logic [15:0] wd);
        bus.CSbar = 1'b0;
        if (wt) begin
            cyc(2);
            bus.DATA_TX = wd;
            bus.TX_WE   = 1'b1;
            cyc(1);
            bus.TX_WE   = 1'b0;
            cyc(4);
        end else begin
            cyc(6);
        end
    endtask

    // Master role: drive MOSI and capture MISO at each SCK rise, SCK = SYS_CLK/8.
    task automatic clock_bits(input int n, input logic [31:0] mosi,
                              inout logic [31:0] cap, inout int busy_bad);
        for (int i = 0; i < n; i++) begin
            bus.MOSI = mosi[n-1-i];
            bus.SCK  = 1'b1;
            cap = {cap[30:0], bus.MISO};
            if (bus.BUSY !== 1'b1 || bus.MISO_OE !== 1'b1) busy_bad++;
            cyc(4);
            bus.SCK = 1'b0;
            cyc(4);
        end
    endtask

    task automatic end_frame();
        cyc(2);
        bus.CSbar = 1'b1;
        cyc(6);
    endtask

    initial begin
        logic [31:0] cap;
        int bb, b_rxv, b_ferr;

        vecs[0] = '{1'b1, 16'h1234, 16, 32'h0000A5C3, 16'hA5C3, 32'h00001234, 1, 0};
        vecs[1] = '{1'b0, 16'h0000,  7, 32'h0000005A, 16'hA5C3, 32'h00000009, 0, 1};
        vecs[2] = '{1'b0, 16'h0000, 20, 32'h000BEEFF, 16'hBEEF, 32'h00012340, 1, 0};
        vecs[3] = '{1'b1, 16'hFFFF,  0, 32'h00000000, 16'hBEEF, 32'h00000000, 0, 0};
        vecs[4] = '{1'b1, 16'h8001, 16, 32'h00001357, 16'h1357, 32'h00008001, 1, 0};

        bus.SCK = 1'b0; bus.CSbar = 1'b1; bus.MOSI = 1'b0;
        bus.DATA_TX = '0; bus.TX_WE = 1'b0;

        // Reset with activity on the pins.
        rstn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.SCK   = ~bus.SCK;
            bus.CSbar = ~bus.CSbar;
        end
        cyc(1);
        check("reset_ctrl_outputs",
              {27'd0, bus.MISO, bus.MISO_OE, bus.RX_VALID, bus.BUSY, bus.FRAME_ERR}, 32'd0);
        check("reset_data_rx", {16'd0, bus.DATA_RX}, 32'd0);
        bus.SCK = 1'b0; bus.CSbar = 1'b1;
        rstn = 1'b1;
        cyc(8);
        check("post_reset_busy_oe", {30'd0, bus.BUSY, bus.MISO_OE}, 32'd0);
        check("post_reset_no_pulses", rxv_cnt + ferr_cnt, 32'd0);

        for (int v = 0; v < 5; v++) begin
            b_rxv = rxv_cnt; b_ferr = ferr_cnt;
            if (vecs[v].we) write_tx(vecs[v].tx);
            cap = '0; bb = 0;
            start_frame(1'b0, 16'h0000);
            check($sformatf("v%0d_busy_at_select", v), {31'd0, bus.BUSY}, 32'd1);
            clock_bits(vecs[v].nbits, vecs[v].mosi, cap, bb);
            end_frame();
            check($sformatf("v%0d_data_rx", v), {16'd0, bus.DATA_RX}, {16'd0, vecs[v].exp_rx});
            check($sformatf("v%0d_miso_capture", v), cap, vecs[v].exp_cap);
            check($sformatf("v%0d_rx_valid_cycles", v), rxv_cnt - b_rxv, vecs[v].exp_rxv);
            check($sformatf("v%0d_frame_err_cycles", v), ferr_cnt - b_ferr, vecs[v].exp_ferr);
            check($sformatf("v%0d_busy_in_frame", v), bb, 32'd0);
            check($sformatf("v%0d_idle_outputs", v),
                  {29'd0, bus.BUSY, bus.MISO_OE, bus.MISO}, 32'd0);
        end

        // TX write in the middle of a frame only affects the next frame.
        write_tx(16'hFFFF);
        cap = '0; bb = 0;
        start_frame(1'b0, 16'h0000);
        clock_bits(8, 32'h11, cap, bb);
        write_tx(16'h5555);
        clock_bits(8, 32'h11, cap, bb);
        end_frame();
        check("midwrite_current_frame", cap, 32'h0000FFFF);
        check("midwrite_rx", {16'd0, bus.DATA_RX}, 32'h00001111);
        cap = '0;
        start_frame(1'b0, 16'h0000);
        clock_bits(16, 32'h2222, cap, bb);
        end_frame();
        check("midwrite_next_frame", cap, 32'h00005555);
        check("midwrite_busy", bb, 32'd0);

        // TX_WE coinciding with the select edge goes straight to the shifter.
        b_rxv = rxv_cnt;
        cap = '0;
        start_frame(1'b1, 16'h3C3C);
        clock_bits(16, 32'hC0DE, cap, bb);
        end_frame();
        check("writethrough_capture", cap, 32'h00003C3C);
        check("writethrough_rx", {16'd0, bus.DATA_RX}, 32'h0000C0DE);
        check("writethrough_rxv", rxv_cnt - b_rxv, 32'd1);
        cap = '0;
        start_frame(1'b0, 16'h0000);
        clock_bits(16, 32'h0000, cap, bb);
        end_frame();
        check("writethrough_hold_kept", cap, 32'h00003C3C);

        // Reset at bit 10 abandons the frame silently.
        write_tx(16'hABCD);
        b_rxv = rxv_cnt; b_ferr = ferr_cnt;
        cap = '0;
        start_frame(1'b0, 16'h0000);
        clock_bits(10, 32'h3FF, cap, bb);
        rstn = 1'b0;
        cyc(3);
        check("midreset_outputs",
              {27'd0, bus.MISO, bus.MISO_OE, bus.RX_VALID, bus.BUSY, bus.FRAME_ERR}, 32'd0);
        check("midreset_data_rx", {16'd0, bus.DATA_RX}, 32'd0);
        rstn = 1'b1;
        cyc(8);
        check("midreset_no_restart", {30'd0, bus.BUSY, bus.MISO_OE}, 32'd0);
        bus.CSbar = 1'b1;
        cyc(8);
        check("midreset_no_rxv", rxv_cnt - b_rxv, 32'd0);
        check("midreset_no_ferr", ferr_cnt - b_ferr, 32'd0);
        cap = '0; bb = 0;
        start_frame(1'b0, 16'h0000);
        clock_bits(16, 32'h0F0F, cap, bb);
        end_frame();
        check("postreset_rx", {16'd0, bus.DATA_RX}, 32'h00000F0F);
        check("postreset_rxv", rxv_cnt - b_rxv, 32'd1);
        check("postreset_ferr", ferr_cnt - b_ferr, 32'd0);
        check("postreset_hold_cleared", cap, 32'h00000000);
        check("postreset_busy", bb, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spi_slave_uc
